puf_response_reader: RTL and testbench

//  Read side of the arbiter-PUF sampling flip-flop. Drives a challenge onto the race-path select lines
//  and fires a launch pulse. After settling, samples the arbiter's captured bit. Packs the bits into

---
 rtl/puf_pkg.sv | 19 +
 rtl/puf_lfsr.sv | 35 +++
 rtl/puf_response_reader.sv | 153 +++++++++++++++
 tb/tb_puf_response_reader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// puf_pkg
//   Shared constants for the arbiter-PUF response reader: FSM state
//   encodings, the challenge LFSR feedback taps and the default seed.
//   Imported by puf_lfsr and puf_response_reader.
package puf_pkg;

  // FSM state encodings
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_APPLY  = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_SAMPLE = 3'd4;
  localparam logic [2:0] S_OUT    = 3'd5;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/puf_lfsr.sv
// puf_lfsr
//   Galois LFSR that generates the race-path challenge. Loads SEED on reset
//   and advances one step on every cycle with i_en high.
// Ports
//   i_clk    clock, rising edge
//   i_rst    synchronous reset, active-high (loads SEED)
//   i_en     advance one step
//   o_state  current LFSR value (the challenge)
module puf_lfsr
  import puf_pkg::*;
#(
  parameter int           W    = 16,
  parameter logic [W-1:0] TAPS = LFSR_TAPS,
  parameter logic [W-1:0] SEED = DEFAULT_SEED
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_state
);

  logic [W-1:0] r_state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= SEED;
    end else if (i_en) begin
      // bit shifted out of the LSB folds back through the tap mask
      r_state <= r_state[0] ? ((r_state >> 1) ^ TAPS) : (r_state >> 1);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/puf_response_reader.sv
// puf_response_reader
//   Read side of the arbiter-PUF sampling flip-flop. Drives a challenge,
//   fires a launch pulse, waits for the race to settle, samples the
//   synchronized arbiter bit and packs bits (first bit in MSB) into
//   WORD_W-bit words handed downstream over valid/ready.
//   Optional feature macro: PUF_VN_DEBIAS_EN (von Neumann debias; each
//   output bit taken from a pair of evaluations, 01->0, 10->1, 00/11 dropped).
// Ports
//   i_clk       clock, rising edge
//   i_rst       synchronous reset, active-high
//   i_start     request one word (only honoured in IDLE or the OUT handshake)
//   o_chal      challenge to race-path muxes
//   o_launch    one-cycle race launch pulse
//   i_resp_bit  arbiter output, asynchronous; 2-flop synchronized here
//   o_data      assembled word
//   o_valid     o_data valid
//   i_ready     downstream accepts o_data
//   o_busy      high in every state except IDLE
//
// state  | meaning
// IDLE   | waiting for i_start
// APPLY  | challenge stable on o_chal
// LAUNCH | o_launch high for one cycle
// SETTLE | SETTLE_CYC-cycle down-count while the race resolves
// SAMPLE | take synchronized bit, step LFSR
// OUT    | word presented, waiting for i_ready
module puf_response_reader
  import puf_pkg::*;
#(
  parameter int              CH_W       = 16,
  parameter int              WORD_W     = 8,
  parameter int              SETTLE_CYC = 4,
  parameter logic [CH_W-1:0] LFSR_SEED  = DEFAULT_SEED
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic [CH_W-1:0]   o_chal,
  output logic              o_launch,
  input  logic              i_resp_bit,
  output logic [WORD_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int SET_W = $clog2(SETTLE_CYC);

  logic [2:0]        r_state;
  logic [SET_W-1:0]  r_settle;
  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_shift;
  logic              r_sync1;
  logic              r_sync2;
`ifdef PUF_VN_DEBIAS_EN
  logic              r_pair;
  logic              r_first;
`endif

  logic              w_step;
  logic [CH_W-1:0]   w_chal;

  assign w_step = (r_state == S_SAMPLE);

  puf_lfsr #(
    .W    (CH_W),
    .TAPS (CH_W'(LFSR_TAPS)),
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (w_step),
    .o_state (w_chal)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_resp_bit;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_settle <= '0;
      r_cnt    <= '0;
      r_shift  <= '0;
`ifdef PUF_VN_DEBIAS_EN
      r_pair   <= 1'b0;
      r_first  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) r_state <= S_APPLY;
        end
        S_APPLY: begin
          r_state <= S_LAUNCH;
        end
        S_LAUNCH: begin
          r_settle <= SET_W'(SETTLE_CYC - 1);
          r_state  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_settle == '0) r_state <= S_SAMPLE;
          else                r_settle <= r_settle - 1'b1;
        end
        S_SAMPLE: begin
`ifdef PUF_VN_DEBIAS_EN
          if (!r_pair) begin
            r_first <= r_sync2;
            r_pair  <= 1'b1;
            r_state <= S_APPLY;
          end else begin
            r_pair <= 1'b0;
            // a differing pair yields its first bit; equal pairs are dropped
            if (r_sync2 != r_first) begin
              r_shift <= {r_shift[WORD_W-2:0], r_first};
              r_cnt   <= r_cnt + 1'b1;
              r_state <= (r_cnt == CNT_W'(WORD_W - 1)) ? S_OUT : S_APPLY;
            end else begin
              r_state <= S_APPLY;
            end
          end
`else
          r_shift <= {r_shift[WORD_W-2:0], r_sync2};
          r_cnt   <= r_cnt + 1'b1;
          r_state <= (r_cnt == CNT_W'(WORD_W - 1)) ? S_OUT : S_APPLY;
`endif
        end
        S_OUT: begin
          if (i_ready) begin
            r_cnt   <= '0;
            r_state <= i_start ? S_APPLY : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_chal   = w_chal;
  assign o_launch = (r_state == S_LAUNCH);
  assign o_valid  = (r_state == S_OUT);
  assign o_busy   = (r_state != S_IDLE);
  assign o_data   = r_shift;

endmodule

// File: tb/tb_puf_response_reader.sv
module tb_puf_response_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] chal;
  logic        launch;
  logic        resp_bit;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int launches = 0;
  int evals = 0;
  int resp_mode = 0;   // 0: constant 1, 1: alternating 1,0 per evaluation

  puf_response_reader dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .o_chal     (chal),
    .o_launch   (launch),
    .i_resp_bit (resp_bit),
    .o_data     (data),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  // advance one cycle; response for each evaluation is set at its launch
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (launch === 1'b1) begin
      launches++;
      resp_bit = (resp_mode == 0) ? 1'b1 : ((evals % 2) == 0);
      evals++;
    end
  endtask

  task automatic wait_valid(input int limit);
    int n;
    n = 0;
    while (valid !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ready = 1'b1; resp_bit = 1'b1;
    repeat (3) tick();
    checks++; if (chal !== 16'hACE1) begin errors++; $display("FAIL reset_chal got=%h exp=%h", chal, 16'hACE1); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (launch !== 1'b0) begin errors++; $display("FAIL reset_launch got=%b exp=0", launch); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data); end
    rst = 1'b0;
    tick();
  endtask

`ifndef PUF_VN_DEBIAS_EN
  task automatic test_single_word();
    int c0;
    resp_mode = 0; launches = 0; ready = 1'b1;
    c0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    checks++; if (chal !== 16'hACE1) begin errors++; $display("FAIL single_chal0 got=%h exp=ACE1", chal); end
    repeat (7) tick();
    checks++; if (chal !== 16'hE270) begin errors++; $display("FAIL single_chal1 got=%h exp=E270", chal); end
    wait_valid(200);
    checks++; if (cyc - c0 !== 57) begin errors++; $display("FAIL single_latency got=%0d exp=57", cyc - c0); end
    checks++; if (data !== 8'hFF) begin errors++; $display("FAIL single_data got=%h exp=FF", data); end
    checks++; if (launches !== 8) begin errors++; $display("FAIL single_launches got=%0d exp=8", launches); end
    tick();
    checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done got=%b%b exp=00", valid, busy); end
  endtask

  task automatic test_hold();
    resp_mode = 1; evals = 0; ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(200);
    checks++; if (data !== 8'hAA) begin errors++; $display("FAIL hold_data got=%h exp=AA", data); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (valid !== 1'b1 || data !== 8'hAA) begin
        errors++; $display("FAIL hold_stable cyc%0d got=%b/%h exp=1/AA", i, valid, data);
      end
      tick();
    end
    ready = 1'b1;
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL hold_release got=%b exp=0", valid); end
    resp_mode = 0;
  endtask

  task automatic test_ignore_start();
    int c0, nval, nbusy, n;
    ready = 1'b1; resp_mode = 0;
    c0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (valid !== 1'b1 && n < 200) begin
      start = ((cyc - c0) == 5) || ((cyc - c0) == 20);
      tick();
      n++;
    end
    start = 1'b0;
    checks++; if (cyc - c0 !== 57) begin errors++; $display("FAIL ignore_latency got=%0d exp=57", cyc - c0); end
    tick();
    nval = 0; nbusy = 0;
    for (int i = 0; i < 30; i++) begin
      if (valid === 1'b1) nval++;
      if (busy === 1'b1) nbusy++;
      tick();
    end
    checks++; if (nval !== 0) begin errors++; $display("FAIL ignore_extra_valid got=%0d exp=0", nval); end
    checks++; if (nbusy !== 0) begin errors++; $display("FAIL ignore_extra_busy got=%0d exp=0", nbusy); end
  endtask

  task automatic test_mid_reset();
    int c0;
    ready = 1'b1; resp_mode = 0;
    c0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    while ((cyc - c0) < 30) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (chal !== 16'hACE1) begin errors++; $display("FAIL rst_chal got=%h exp=ACE1", chal); end
    checks++; if (valid !== 1'b0 || launch !== 1'b0) begin errors++; $display("FAIL rst_outs got=%b%b exp=00", valid, launch); end
    c0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(200);
    checks++; if (cyc - c0 !== 57) begin errors++; $display("FAIL rst_latency got=%0d exp=57", cyc - c0); end
    checks++; if (data !== 8'hFF) begin errors++; $display("FAIL rst_data got=%h exp=FF", data); end
    tick();
  endtask

  task automatic test_back_to_back();
    int c1;
    ready = 1'b0; resp_mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(200);
    start = 1'b1; ready = 1'b1;
    c1 = cyc;
    tick();
    start = 1'b0;
    checks++; if (valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got=%b%b exp=01", valid, busy); end
    wait_valid(200);
    checks++; if (cyc - c1 !== 57) begin errors++; $display("FAIL b2b_latency got=%0d exp=57", cyc - c1); end
    checks++; if (data !== 8'hFF) begin errors++; $display("FAIL b2b_data got=%h exp=FF", data); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", busy); end
  endtask
`else
  task automatic test_vn_alternate();
    int c0;
    resp_mode = 1; evals = 0; ready = 1'b1;
    c0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(400);
    checks++; if (cyc - c0 !== 113) begin errors++; $display("FAIL vn_latency got=%0d exp=113", cyc - c0); end
    checks++; if (data !== 8'hFF) begin errors++; $display("FAIL vn_data got=%h exp=FF", data); end
    checks++; if (evals !== 16) begin errors++; $display("FAIL vn_evals got=%0d exp=16", evals); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL vn_idle got=%b exp=0", busy); end
  endtask

  task automatic test_vn_constant();
    int nval, nidle;
    resp_mode = 0; ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    nval = 0; nidle = 0;
    for (int i = 0; i < 1000; i++) begin
      if (valid === 1'b1) nval++;
      if (busy !== 1'b1) nidle++;
      tick();
    end
    checks++; if (nval !== 0) begin errors++; $display("FAIL vn_const_valid got=%0d exp=0", nval); end
    checks++; if (nidle !== 0) begin errors++; $display("FAIL vn_const_busy got=%0d exp=0", nidle); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || chal !== 16'hACE1) begin errors++; $display("FAIL vn_rst got=%b/%h exp=0/ACE1", busy, chal); end
  endtask
`endif

  initial begin
    test_reset();
`ifndef PUF_VN_DEBIAS_EN
    test_single_word();
    test_hold();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
`else
    test_vn_alternate();
    test_vn_constant();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
